// File: rtl/uart_rx_assembler.sv
// ============================================================================
// Module      : uart_rx_assembler
// Description : 8N1 UART receiver that packs DATASIZE/PAYLOAD_BITS consecutive
//               bytes (first byte in the MSBs) into one DATASIZE-bit message,
//               with stop-bit error detection, line-break hold-off and
//               inter-byte timeout for partial messages.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_assembler #(
    parameter int DATASIZE     = 128,
    parameter int CLK_HZ       = 100_000_000,
    parameter int BIT_RATE     = 9_600,
    parameter int PAYLOAD_BITS = 8,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                rxd_pin,
    output logic [DATASIZE-1:0] data,
    output logic                data_valid,
    output logic                frame_err,
    output logic                busy,
    output logic [3:0]          led
);

    // Clock cycles per bit and derived sizes
    localparam int CPB    = CLK_HZ / BIT_RATE;
    localparam int NBYTES = DATASIZE / PAYLOAD_BITS;
    localparam int TMO    = TIMEOUT_BITS * CPB;

    localparam int CNT_W  = (CPB > 1)          ? $clog2(CPB)          : 1;
    localparam int BIT_W  = (PAYLOAD_BITS > 1) ? $clog2(PAYLOAD_BITS) : 1;
    localparam int NB_W   = (NBYTES > 1)       ? $clog2(NBYTES)       : 1;
    localparam int IDLE_W = (TMO > 1)          ? $clog2(TMO)          : 1;

    // Terminal counts: counters run from 0 to these values inclusive
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_LAST = CNT_W'(CPB - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PAYLOAD_BITS - 1);
    localparam logic [NB_W-1:0]   NB_LAST   = NB_W'(NBYTES - 1);
    localparam logic [IDLE_W-1:0] TMO_LAST  = IDLE_W'(TMO - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t                    state;
    logic                      rx_meta;
    logic                      rxs;
    logic [CNT_W-1:0]          cyc_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [PAYLOAD_BITS-1:0]   rx_byte;
    logic [NB_W-1:0]           byte_cnt;
    logic [IDLE_W-1:0]         idle_cnt;
    logic [DATASIZE-1:0]       shreg;
    logic [DATASIZE-1:0]       shreg_next;
    logic                      valid_toggle;
    logic                      err_sticky;

    // Shift register contents once the byte just received is appended (shift
    // form keeps this legal even when a message is a single byte)
    assign shreg_next = (shreg << PAYLOAD_BITS) | DATASIZE'(rx_byte);

    // Status outputs decode straight from registered state
    assign busy = (state != IDLE);
    assign led  = {(byte_cnt != '0), err_sticky, valid_toggle, busy};

    // Two-flop synchroniser for the asynchronous pin; idles high out of reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rxd_pin;
            rxs     <= rx_meta;
        end
    end

    // Frame FSM, byte assembly, message output and partial-message timeout
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            cyc_cnt      <= '0;
            bit_idx      <= '0;
            rx_byte      <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            shreg        <= '0;
            data         <= '0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
            valid_toggle <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            // Idle timer only runs with a partial message pending in IDLE.
            // A start edge in the expiry cycle still sees the count cleared,
            // because byte acceptance happens a full frame later.
            if (state == IDLE && byte_cnt != '0) begin
                if (idle_cnt == TMO_LAST) begin
                    idle_cnt <= '0;
                    byte_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state   <= START;
                        cyc_cnt <= '0;
                    end
                end

                // Mid-start-bit check rejects short glitches silently
                START: begin
                    if (cyc_cnt == HALF_LAST) begin
                        cyc_cnt <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                // LSB first: each sample enters at the top and shifts down
                DATA: begin
                    if (cyc_cnt == FULL_LAST) begin
                        cyc_cnt <= '0;
                        rx_byte <= (rx_byte >> 1) | (PAYLOAD_BITS'(rxs) << (PAYLOAD_BITS - 1));
                        if (bit_idx == BIT_LAST) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cyc_cnt == FULL_LAST) begin
                        cyc_cnt <= '0;
                        if (rxs) begin
                            state <= IDLE;
                            shreg <= shreg_next;
                            if (byte_cnt == NB_LAST) begin
                                data         <= shreg_next;
                                data_valid   <= 1'b1;
                                valid_toggle <= ~valid_toggle;
                                byte_cnt     <= '0;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end else begin
                            // Bad stop bit: drop the byte and any partial message
                            frame_err  <= 1'b1;
                            err_sticky <= 1'b1;
                            byte_cnt   <= '0;
                            state      <= BREAK;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + 1'b1;
                    end
                end

                // Wait out a held-low line before looking for a new start bit
                BREAK: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_assembler.sv
// ============================================================================
// Module      : tb_uart_rx_assembler
// Description : Self-checking bench for uart_rx_assembler (CPB=10, 4 bytes per
//               message) with a message-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_assembler;

    localparam int CPB = 10;
    localparam int TMO = 20 * CPB;

    logic        clk = 1'b0;
    logic        resetn;
    logic        rxd_pin;
    logic [31:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        busy;
    logic [3:0]  led;

    uart_rx_assembler #(
        .DATASIZE    (32),
        .CLK_HZ      (1_000_000),
        .BIT_RATE    (100_000),
        .PAYLOAD_BITS(8),
        .TIMEOUT_BITS(20)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .rxd_pin   (rxd_pin),
        .data      (data),
        .data_valid(data_valid),
        .frame_err (frame_err),
        .busy      (busy),
        .led       (led)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Observation counters filled by the monitor
    int   vcnt     = 0;
    int   fcnt     = 0;
    int   busy_run = 0;
    int   busy_max = 0;
    int   led1_bad = 0;
    logic led1_prev = 1'b0;

    // Reference model: pending bytes of the current message and expectations
    logic [7:0]  q[$];
    int          exp_v      = 0;
    int          exp_f      = 0;
    logic [31:0] exp_data   = '0;
    logic        exp_sticky = 1'b0;
    logic        exp_tog    = 1'b0;
    int          gap        = 0;

    // Monitor: counts strobe cycles and checks led[1] follows data_valid
    always @(negedge clk) begin
        if (resetn) begin
            if (data_valid) vcnt++;
            if (frame_err)  fcnt++;
            if (busy) begin
                busy_run++;
                if (busy_run > busy_max) busy_max = busy_run;
            end else begin
                busy_run = 0;
            end
            if (led[1] !== (led1_prev ^ data_valid)) led1_bad++;
            led1_prev = led[1];
        end else begin
            led1_prev = 1'b0;
            busy_run  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model of one received frame at message level
    task automatic model_frame(input logic [7:0] b, input logic good);
        gap = 0;
        if (good) begin
            q.push_back(b);
            if (q.size() == 4) begin
                exp_data = {q[0], q[1], q[2], q[3]};
                exp_v++;
                exp_tog = ~exp_tog;
                q.delete();
            end
        end else begin
            exp_f++;
            exp_sticky = 1'b1;
            q.delete();
        end
    endtask

    // Hold the line idle; a long enough gap drops a partial message
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        gap += n;
        if (gap >= TMO && q.size() > 0) q.delete();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stopb);
        @(negedge clk);
        rxd_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd_pin = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_pin = stopb;
        repeat (CPB) @(negedge clk);
        rxd_pin = 1'b1;
        model_frame(b, stopb);
    endtask

    task automatic check_all(input string tag);
        @(posedge clk);
        #2;
        check({tag, "_valid_cnt"}, vcnt, exp_v);
        check({tag, "_data"},      data, exp_data);
        check({tag, "_ferr_cnt"},  fcnt, exp_f);
        check({tag, "_led2"},      32'(led[2]), 32'(exp_sticky));
        check({tag, "_led3"},      32'(led[3]), 32'(q.size() != 0));
        check({tag, "_led1"},      32'(led[1]), 32'(exp_tog));
        check({tag, "_busy"},      32'(busy), 32'd0);
        check({tag, "_led1_track"}, led1_bad, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  data, 32'h0);
        check({tag, "_dv"},    32'(data_valid), 32'd0);
        check({tag, "_ferr"},  32'(frame_err), 32'd0);
        check({tag, "_busy"},  32'(busy), 32'd0);
        check({tag, "_led"},   32'(led), 32'd0);
    endtask

    initial begin
        logic [7:0] msg[4];
        logic [7:0] b2;
        rxd_pin = 1'b1;
        resetn  = 1'b1;
        #1 resetn = 1'b0;
        repeat (5) @(negedge clk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        idle(5);

        // 1: one full message back-to-back
        send_frame(8'hDE, 1'b1);
        send_frame(8'hAD, 1'b1);
        send_frame(8'hBE, 1'b1);
        send_frame(8'hEF, 1'b1);
        idle(20);
        check("t1_data_const", data, 32'hDEADBEEF);
        check_all("t1");

        // 2: bad stop bit, then a clean message
        send_frame(8'h55, 1'b0);
        idle(5);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        idle(20);
        check("t2_data_const", data, 32'h11223344);
        check_all("t2");

        // 3: partial message times out, next message starts clean
        send_frame(8'hA5, 1'b1);
        send_frame(8'h5A, 1'b1);
        idle(20);
        check_all("t3_pending");
        idle(250);
        check_all("t3_timeout");
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        send_frame(8'h04, 1'b1);
        idle(20);
        check("t3_data_const", data, 32'h01020304);
        check_all("t3");

        // 4: short glitch is rejected
        busy_max = 0;
        @(negedge clk);
        rxd_pin = 1'b0;
        repeat (3) @(negedge clk);
        rxd_pin = 1'b1;
        idle(30);
        check("t4_busy_short", 32'(busy_max > 0 && busy_max < CPB), 32'd1);
        check_all("t4");

        // 5: reset during bit 4 of the second byte
        send_frame(8'h10, 1'b1);
        @(negedge clk);
        b2 = 8'hAD;
        rxd_pin = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxd_pin = b2[i];
            repeat (CPB) @(negedge clk);
        end
        rxd_pin = b2[4];
        repeat (CPB / 2) @(negedge clk);
        resetn  = 1'b0;
        rxd_pin = 1'b1;
        q.delete();
        exp_data   = '0;
        exp_sticky = 1'b0;
        exp_tog    = 1'b0;
        gap        = 0;
        @(posedge clk);
        #2;
        check_reset_outputs("t5_in_reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        idle(5);
        send_frame(8'h00, 1'b1);
        send_frame(8'h01, 1'b1);
        send_frame(8'h02, 1'b1);
        send_frame(8'h03, 1'b1);
        idle(20);
        check("t5_data_const", data, 32'h00010203);
        check_all("t5");

        // 6: line held low for 30 bit-times (break)
        @(negedge clk);
        rxd_pin = 1'b0;
        repeat (30 * CPB) @(negedge clk);
        check("t6_busy_in_break", 32'(busy), 32'd1);
        check("t6_one_ferr", fcnt, exp_f + 1);
        rxd_pin = 1'b1;
        exp_f++;
        exp_sticky = 1'b1;
        q.delete();
        gap = 0;
        idle(10);
        for (int i = 0; i < 4; i++) msg[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) send_frame(msg[i], 1'b1);
        idle(20);
        check("t6_data_rand", data, {msg[0], msg[1], msg[2], msg[3]});
        check_all("t6");

        // Randomized messages with random inter-frame gaps
        for (int m = 0; m < 3; m++) begin
            for (int i = 0; i < 4; i++) begin
                send_frame(8'($urandom), 1'b1);
                idle($urandom_range(0, 20));
            end
            idle(20);
            check_all("rand_msg");
        end

        // Randomized partial message that times out
        send_frame(8'($urandom), 1'b1);
        send_frame(8'($urandom), 1'b1);
        idle(10);
        check_all("rand_partial");
        idle(300);
        check_all("rand_partial_to");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
